prog_loader_monitor: RTL
========================

Name: prog_loader_monitor

Overview:
- Synthesizable boot-and-run controller that sits between a program source and the `processor` core.
- Accepts a valid/ready stream of instruction words and writes them into instruction memory through `instr_we`/`instr_feed`/`instr_write_address`.
- Holds the core in reset for a programmable number of cycles, then releases it and supervises the run.
- During the run it buffers `Print` values in a FIFO and terminates on `End_signal` or on a cycle timeout.

Parameters:
- ADDR_W, 10, instruction address width
- DATA_W, 32, instruction and print data width
- MAX_WORDS, 1024, maximum words loaded per program (≤ 2^ADDR_W)
- RST_CYCLES, 2, cycles `cpu_rst` is held after load (≥ 1)
- RUN_TIMEOUT, 1000, run-cycle limit; 0 disables the timeout
- FIFO_DEPTH, 8, print FIFO entries (power of 2, ≥ 2)
- CNT_W, 32, cycle counter width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse: begin a load/run session
- boot_pc  in  ADDR_W  start PC, latched on an accepted start
- load_valid  in  1  stream word valid
- load_data  in  DATA_W  instruction word
- load_last  in  1  final word of the program
- load_ready  out  1  loader accepts a word
- instr_we  out  1  instruction memory write enable
- instr_feed  out  DATA_W  instruction memory write data
- instr_write_address  out  ADDR_W  instruction memory write address
- cpu_rst  out  1  reset to the core
- init_pc  out  ADDR_W  latched boot_pc to the core
- End_signal  in  1  core finished
- Print  in  1  core print strobe
- toBePrinted  in  DATA_W  core print value
- pr_valid  out  1  print FIFO not empty
- pr_data  out  DATA_W  FIFO head (first-word-fall-through)
- pr_ready  in  1  consumer pops the head
- words_loaded  out  ADDR_W+1  words written this session
- run_cycles  out  CNT_W  cycles spent in RUN
- done  out  1  session ended by End_signal
- timeout  out  1  session ended by timeout
- overflow  out  1  sticky: at least one print was dropped

Behaviour:
- Reset (rst=1 at a clk edge, from any state, including mid-load or mid-run):
  - state=IDLE, cpu_rst=1, instr_we=0, load_ready=0.
  - instr_feed=0, instr_write_address=0, init_pc=0.
  - FIFO emptied (pr_valid=0).
  - words_loaded=0, run_cycles=0, done=timeout=overflow=0.
  - A partial load is abandoned; no further writes occur.
- States: IDLE, LOAD, HOLD, RUN, DONE, TMO. cpu_rst=1 in every state except RUN.
- IDLE:
  - start=1 → LOAD.
  - Latch init_pc=boot_pc.
  - Clear words_loaded, run_cycles, done, timeout, overflow and the FIFO.
- LOAD:
  - load_ready=1 combinationally while in LOAD; 0 in every other state.
  - Beat accepted when load_valid && load_ready.
  - Write latency is 1 cycle: the next cycle has instr_we=1, instr_feed=load_data, instr_write_address=words_loaded (pre-increment).
  - words_loaded increments on each accepted beat.
  - instr_we=0 on cycles without an accepted beat.
  - Go to HOLD on the beat that has load_last=1, or on the MAX_WORDS-th beat (whichever comes first).
  - load_ready drops the cycle after the terminating beat. Its write still occurs in the first HOLD cycle.
- HOLD:
  - Counts RST_CYCLES cycles, then → RUN.
  - cpu_rst deasserts on the first RUN cycle.
- RUN:
  - cpu_rst=0; run_cycles increments every RUN cycle.
  - Print=1 pushes toBePrinted into the FIFO.
  - Push when full and no pop in the same cycle: the value is dropped and overflow is set (sticky).
  - Push and pop in the same cycle while full: the push succeeds, no overflow.
  - End_signal=1 → DONE, done=1. A Print in that same cycle is still captured.
  - If RUN_TIMEOUT≠0 and run_cycles reaches RUN_TIMEOUT → TMO, timeout=1.
  - End_signal and timeout in the same cycle: End wins (DONE).
- DONE/TMO:
  - cpu_rst=1; run_cycles frozen.
  - The FIFO continues to drain via pr_ready; no pushes.
  - start=1 → a new session exactly as from IDLE (FIFO cleared, flags cleared).
- start is ignored in LOAD, HOLD and RUN.
- FIFO pop: pr_valid && pr_ready. pr_data is don't-care when pr_valid=0. Order is strictly FIFO.
- Counters saturate; no wrap.

Test Plan:
- Load of 5 words (0x11..0x15, load_last on the 5th), boot_pc=0x20 → five instr_we pulses at addresses 0–4, each 1 cycle after acceptance. words_loaded=5. init_pc=0x20. cpu_rst low exactly RST_CYCLES=2 cycles after the last write cycle.
- load_valid toggling every other cycle during load → writes only on accepted beats. Addresses are contiguous 0..N-1 with no gaps or duplicates.
- RUN: Print with 0xA, 0xB, 0xC and pr_ready=1 → pr_data presents 0xA, 0xB, 0xC in order. End_signal at run cycle 7 → done=1, run_cycles=7, cpu_rst=1.
- FIFO_DEPTH=8, pr_ready=0, 10 Prints → first 8 values retained, overflow=1. Draining yields exactly those 8 values. A full-FIFO push with simultaneous pop sets no overflow.
- RUN_TIMEOUT=50, no End_signal → TMO at run_cycles=50, timeout=1. End_signal in the same cycle as the timeout → done=1, timeout=0.
- rst asserted on the 3rd accepted load beat → next cycle all outputs at reset values, instr_we=0. A subsequent start reloads from address 0.

Source files
------------

// File: rtl/prog_loader_monitor.sv
// Boot-and-run controller: streams a program into instruction memory, holds the
// core in reset, then supervises the run while buffering print values.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | waiting for start after reset
//   S_LOAD | accepting instruction words, one write per accepted beat
//   S_HOLD | core still in reset, down-counting RST_CYCLES
//   S_RUN  | core running, prints captured, cycles counted
//   S_DONE | run ended by End_signal, FIFO may still drain
//   S_TMO  | run ended by timeout, FIFO may still drain
module prog_loader_monitor #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int MAX_WORDS   = 1024,
    parameter int RST_CYCLES  = 2,
    parameter int RUN_TIMEOUT = 1000,
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] boot_pc,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_ready,
    output logic              instr_we,
    output logic [DATA_W-1:0] instr_feed,
    output logic [ADDR_W-1:0] instr_write_address,
    output logic              cpu_rst,
    output logic [ADDR_W-1:0] init_pc,
    input  logic              End_signal,
    input  logic              Print,
    input  logic [DATA_W-1:0] toBePrinted,
    output logic              pr_valid,
    output logic [DATA_W-1:0] pr_data,
    input  logic              pr_ready,
    output logic [ADDR_W:0]   words_loaded,
    output logic [CNT_W-1:0]  run_cycles,
    output logic              done,
    output logic              timeout,
    output logic              overflow
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W:0]  MAX_WL  = (ADDR_W+1)'(MAX_WORDS);
    localparam logic [CNT_W-1:0] TMO_L   = CNT_W'(RUN_TIMEOUT);
    localparam logic [CNT_W-1:0] HOLD_L  = CNT_W'(RST_CYCLES - 1);
    localparam logic [PTR_W:0]   DEPTH_L = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE, S_TMO} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_pc_q, init_pc_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] feed_q, feed_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W:0]   words_q, words_d, words_inc;
    logic [CNT_W-1:0]  run_q, run_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;
    logic              ovf_q, ovf_d;
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              push, pop, fifo_clr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    assign words_inc = words_q + 1'b1;
    assign pop       = (cnt_q != '0) && pr_ready;

    always_comb begin
        state_d   = state_q;
        init_pc_d = init_pc_q;
        we_d      = 1'b0;
        feed_d    = feed_q;
        waddr_d   = waddr_q;
        words_d   = words_q;
        run_d     = run_q;
        hold_d    = hold_q;
        done_d    = done_q;
        tmo_d     = tmo_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        fifo_clr  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE, S_TMO: begin
                if (start) begin
                    state_d   = S_LOAD;
                    init_pc_d = boot_pc;
                    words_d   = '0;
                    run_d     = '0;
                    done_d    = 1'b0;
                    tmo_d     = 1'b0;
                    ovf_d     = 1'b0;
                    fifo_clr  = 1'b0 | 1'b1;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    we_d    = 1'b1;
                    feed_d  = load_data;
                    waddr_d = words_q[ADDR_W-1:0];
                    if (words_q != '1) words_d = words_inc;
                    if (load_last || words_inc == MAX_WL) begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_L;
                    end
                end
            end
            S_HOLD: begin
                if (hold_q == '0) state_d = S_RUN;
                else              hold_d  = hold_q - 1'b1;
            end
            S_RUN: begin
                if (run_q != '1) run_d = run_q + 1'b1;
                // a full FIFO still accepts a push when the head leaves this cycle
                if (Print) begin
                    if (cnt_q != DEPTH_L || pop) push  = 1'b1;
                    else                         ovf_d = 1'b1;
                end
                if (End_signal) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else if (TMO_L != '0 && run_d == TMO_L) begin
                    state_d = S_TMO;
                    tmo_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (fifo_clr) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (pop)  rd_d = rd_q + 1'b1;
            if (push) wr_d = wr_q + 1'b1;
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            init_pc_q <= '0;
            we_q      <= 1'b0;
            feed_q    <= '0;
            waddr_q   <= '0;
            words_q   <= '0;
            run_q     <= '0;
            hold_q    <= '0;
            done_q    <= 1'b0;
            tmo_q     <= 1'b0;
            ovf_q     <= 1'b0;
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            init_pc_q <= init_pc_d;
            we_q      <= we_d;
            feed_q    <= feed_d;
            waddr_q   <= waddr_d;
            words_q   <= words_d;
            run_q     <= run_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            tmo_q     <= tmo_d;
            ovf_q     <= ovf_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
        end
    end

    // storage needs no reset: pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= toBePrinted;
    end

    assign load_ready          = (state_q == S_LOAD);
    assign cpu_rst             = (state_q != S_RUN);
    assign instr_we            = we_q;
    assign instr_feed          = feed_q;
    assign instr_write_address = waddr_q;
    assign init_pc             = init_pc_q;
    assign pr_valid            = (cnt_q != '0);
    assign pr_data             = mem[rd_q];
    assign words_loaded        = words_q;
    assign run_cycles          = run_q;
    assign done                = done_q;
    assign timeout             = tmo_q;
    assign overflow            = ovf_q;
endmodule
